axi_read_protocol: RTL

Protocol-level FSM for the AXI read path (AR and R channels), the read-side counterpart of the write-path protocol FSM in the AXI ILA verification model. It registers read-address requests, tracks one outstanding burst, sequences R beats with WAIT/COMMIT/ASSERT handshake states, generates `axi_rlast` from the captured burst length and computes the per-beat address. Outputs feed the ILA refinement checks alongside the write-path FSM.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_beat_addr_gen.sv | 43 ++++
 rtl/axi_read_protocol.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI protocol definitions: handshake FSM state encodings, burst and
// response codes, and the beat-size helper used by the address generator.
package axi_pkg;

  localparam logic [1:0] WAIT   = 2'b00;
  localparam logic [1:0] COMMIT = 2'b01;
  localparam logic [1:0] ASSERT = 2'b10;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [7:0] size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// WRAP boundary arithmetic is compiled only when AXI_RD_WRAP_EN is defined.
module axi_beat_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] incr_addr;

  assign step      = AW'(size_bytes(size));
  assign incr_addr = addr + step;

`ifdef AXI_RD_WRAP_EN
  // Mask covers the wrap window of size*(len+1) bytes.
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] wrap_addr;
  assign wrap_mask = step * (AW'(len) + AW'(1)) - AW'(1);
  assign wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
`ifdef AXI_RD_WRAP_EN
      BURST_WRAP:  next_addr = wrap_addr;
`endif
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_read_protocol.sv
// AXI read-path protocol FSM: registered AR and R channels, one outstanding
// burst, rlast and per-beat address generation. Optional macro: AXI_RD_WRAP_EN.
module axi_read_protocol
  import axi_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          axi_aclk,
  input  logic          rst_n,
  input  logic [AW-1:0] araddr_in,
  input  logic [7:0]    arlen_in,
  input  logic [2:0]    arsize_in,
  input  logic [1:0]    arburst_in,
  input  logic          arvalid_in,
  input  logic          arready_in,
  input  logic [DW-1:0] rdata_in,
  input  logic [1:0]    rresp_in,
  input  logic          rvalid_in,
  input  logic          rready_in,
  output logic [AW-1:0] axi_araddr,
  output logic [7:0]    axi_arlen,
  output logic [2:0]    axi_arsize,
  output logic [1:0]    axi_arburst,
  output logic          axi_arvalid,
  output logic          axi_arready,
  output logic [DW-1:0] axi_rdata,
  output logic [1:0]    axi_rresp,
  output logic          axi_rlast,
  output logic          axi_rvalid,
  output logic          axi_rready,
  output logic          r_active,
  output logic [AW-1:0] beat_addr
);

  logic [1:0]    ar_state;
  logic [1:0]    r_state;
  logic [7:0]    beats_left;
  logic [AW-1:0] next_addr;
  logic          ar_commit;
  logic          r_done;
  logic          r_advance;

  assign ar_commit = (ar_state == COMMIT);
  assign r_done    = (r_state == COMMIT) && axi_rlast;
  assign r_advance = (r_state == COMMIT) && !axi_rlast;

  axi_beat_addr_gen #(.AW(AW)) u_addr_gen (
    .addr      (beat_addr),
    .size      (axi_arsize),
    .len       (axi_arlen),
    .burst     (axi_arburst),
    .next_addr (next_addr)
  );

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state    <= WAIT;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arsize  <= '0;
      axi_arburst <= '0;
      axi_arvalid <= 1'b0;
      axi_arready <= 1'b0;
    end else begin
      case (ar_state)
        WAIT: begin
          // Requests arriving while a burst is outstanding are left pending.
          if (arvalid_in && !r_active) begin
            axi_araddr  <= araddr_in;
            axi_arlen   <= arlen_in;
            axi_arsize  <= arsize_in;
            axi_arburst <= arburst_in;
            axi_arvalid <= 1'b1;
            if (arready_in) begin
              axi_arready <= 1'b1;
              ar_state    <= COMMIT;
            end else begin
              ar_state    <= ASSERT;
            end
          end
        end
        ASSERT: begin
          if (arready_in) begin
            axi_arready <= 1'b1;
            ar_state    <= COMMIT;
          end
        end
        COMMIT: begin
          axi_arvalid <= 1'b0;
          axi_arready <= 1'b0;
          ar_state    <= WAIT;
        end
        default: ar_state <= WAIT;
      endcase
    end
  end

  // Burst tracking; AR commit and R completion never coincide because AR
  // only accepts while r_active is low.
  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      beats_left <= '0;
      beat_addr  <= '0;
    end else if (ar_commit) begin
      r_active   <= 1'b1;
      beats_left <= axi_arlen;
      beat_addr  <= axi_araddr;
    end else if (r_done) begin
      r_active   <= 1'b0;
    end else if (r_advance) begin
      if (beats_left != 8'd0)
        beats_left <= beats_left - 8'd1;
      beat_addr <= next_addr;
    end
  end

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT;
      axi_rdata  <= '0;
      axi_rresp  <= '0;
      axi_rlast  <= 1'b0;
      axi_rvalid <= 1'b0;
      axi_rready <= 1'b0;
    end else begin
      case (r_state)
        WAIT: begin
          if (r_active && rvalid_in) begin
            axi_rdata  <= rdata_in;
            axi_rresp  <= rresp_in;
            axi_rvalid <= 1'b1;
            axi_rlast  <= (beats_left == 8'd0);
            axi_rready <= rready_in;
            r_state    <= rready_in ? COMMIT : ASSERT;
          end
        end
        ASSERT: begin
          if (rready_in) begin
            axi_rready <= 1'b1;
            r_state    <= COMMIT;
          end
        end
        COMMIT: begin
          if (axi_rlast) begin
            axi_rvalid <= 1'b0;
            axi_rready <= 1'b0;
            axi_rlast  <= 1'b0;
            r_state    <= WAIT;
          end else if (rvalid_in) begin
            // beats_left decrements this same edge, so the next beat is last at 1.
            axi_rdata  <= rdata_in;
            axi_rresp  <= rresp_in;
            axi_rlast  <= (beats_left == 8'd1);
            axi_rready <= rready_in;
            r_state    <= rready_in ? COMMIT : ASSERT;
          end else begin
            axi_rvalid <= 1'b0;
            axi_rready <= 1'b0;
            axi_rlast  <= 1'b0;
            r_state    <= WAIT;
          end
        end
        default: r_state <= WAIT;
      endcase
    end
  end

endmodule
